// File: rtl/demux_1x4_if.sv
// Signal bundle between a single data source and the 1-to-4 demultiplexer.
// The source drives data, select and enable; the demux returns the four lanes.
interface demux_1x4_if #(
    parameter int DATA_W = 1
);
    logic                  en;
    logic [DATA_W-1:0]     i;
    logic                  s0;
    logic                  s1;
    logic [4*DATA_W-1:0]   y;
    logic [3:0]            lane_active;

    modport master (
        output en, i, s0, s1,
        input  y, lane_active
    );

    modport slave (
        input  en, i, s0, s1,
        output y, lane_active
    );
endinterface

// File: rtl/demux_1x4.sv
// Steers one input word to one of four lanes selected by {s1,s0}; unselected lanes read zero.
// Outputs are registered (one-cycle latency) or purely combinational, chosen by REG_OUT.
module demux_1x4 #(
    parameter int DATA_W  = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    demux_1x4_if.slave  bus
);
    logic [4*DATA_W-1:0] w_y;
    logic [3:0]          w_lane_active;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_y           = '0;
        w_lane_active = '0;
        if (bus.en) begin
            case ({bus.s1, bus.s0})
                2'b00: begin
                    w_y[0*DATA_W +: DATA_W] = bus.i;
                    w_lane_active           = 4'b0001;
                end
                2'b01: begin
                    w_y[1*DATA_W +: DATA_W] = bus.i;
                    w_lane_active           = 4'b0010;
                end
                2'b10: begin
                    w_y[2*DATA_W +: DATA_W] = bus.i;
                    w_lane_active           = 4'b0100;
                end
                2'b11: begin
                    w_y[3*DATA_W +: DATA_W] = bus.i;
                    w_lane_active           = 4'b1000;
                end
                // An X/Z select falls through here and leaves every lane at zero.
                default: begin
                    w_y           = '0;
                    w_lane_active = '0;
                end
            endcase
        end
    end

    if (REG_OUT) begin : g_reg
        logic [4*DATA_W-1:0] r_y;
        logic [3:0]          r_lane_active;

        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_y           <= '0;
                r_lane_active <= '0;
            end else begin
                r_y           <= w_y;
                r_lane_active <= w_lane_active;
            end
        end

        assign bus.y           = r_y;
        assign bus.lane_active = r_lane_active;
    end else begin : g_comb
        // Clock and reset have no job in the combinational build.
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk ^ rst;

        assign bus.y           = w_y;
        assign bus.lane_active = w_lane_active;
    end
endmodule

// File: tb/tb_demux_1x4.sv
// Scoreboard bench for demux_1x4: registered 1-bit and 8-bit builds plus a combinational build.
// Expected lanes come from a shift-based model and are queued when stimulus is driven.
module tb_demux_1x4;
    typedef struct {
        int unsigned dut;
        string       tag;
        logic [31:0] y;
        logic [3:0]  la;
    } exp_t;

    logic clk;
    logic rst1, rst8, rst_c;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    demux_1x4_if #(.DATA_W(1)) bus1 ();
    demux_1x4_if #(.DATA_W(8)) bus8 ();
    demux_1x4_if #(.DATA_W(1)) busc ();

    demux_1x4 #(.DATA_W(1), .REG_OUT(1'b1)) dut_r1 (.clk(clk), .rst(rst1),  .bus(bus1));
    demux_1x4 #(.DATA_W(8), .REG_OUT(1'b1)) dut_r8 (.clk(clk), .rst(rst8),  .bus(bus8));
    demux_1x4 #(.DATA_W(1), .REG_OUT(1'b0)) dut_c  (.clk(clk), .rst(rst_c), .bus(busc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_y(bit r, bit en, logic [1:0] sel, logic [7:0] d, int w);
        logic [31:0] dd;
        if (r || !en) return 32'h0;
        dd = (w == 1) ? {31'b0, d[0]} : {24'b0, d};
        return dd << (int'(sel) * w);
    endfunction

    function automatic logic [3:0] model_la(bit r, bit en, logic [1:0] sel);
        if (r || !en) return 4'b0000;
        return 4'b0001 << sel;
    endfunction

    task automatic drive1(input string tag, input bit r, input bit en, input logic [1:0] sel, input logic d);
        exp_t e;
        @(negedge clk);
        rst1     = r;
        bus1.en  = en;
        bus1.s1  = sel[1];
        bus1.s0  = sel[0];
        bus1.i   = d;
        e.dut    = 0;
        e.tag    = tag;
        e.y      = model_y(r, en, sel, {7'b0, d}, 1);
        e.la     = model_la(r, en, sel);
        sb.push_back(e);
    endtask

    task automatic drive8(input string tag, input bit r, input bit en, input logic [1:0] sel, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        rst8     = r;
        bus8.en  = en;
        bus8.s1  = sel[1];
        bus8.s0  = sel[0];
        bus8.i   = d;
        e.dut    = 1;
        e.tag    = tag;
        e.y      = model_y(r, en, sel, d, 8);
        e.la     = model_la(r, en, sel);
        sb.push_back(e);
    endtask

    // Everything queued before an edge belongs to that edge; compare just after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                check({e.tag, "_y"},    {28'b0, bus1.y}, e.y);
                check({e.tag, "_la"},   {28'b0, bus1.lane_active}, {28'b0, e.la});
                check({e.tag, "_ones"}, 32'($countones(bus1.y)), 32'($countones(e.y)));
            end else begin
                check({e.tag, "_y"},  bus8.y, e.y);
                check({e.tag, "_la"}, {28'b0, bus8.lane_active}, {28'b0, e.la});
            end
        end
    end

    initial begin
        logic [1:0] rsel;
        logic [7:0] rdat;
        n_checks = 0;
        n_errors = 0;
        rst1 = 1'b1; rst8 = 1'b1; rst_c = 1'b0;
        bus1.en = 1'b0; bus1.i = '0; bus1.s0 = 1'b0; bus1.s1 = 1'b0;
        bus8.en = 1'b0; bus8.i = '0; bus8.s0 = 1'b0; bus8.s1 = 1'b0;
        busc.en = 1'b0; busc.i = '0; busc.s0 = 1'b0; busc.s1 = 1'b0;

        // Reset dominates en/sel/data, holds while asserted, then releases cleanly.
        drive1("rst_a",   1'b1, 1'b1, 2'b11, 1'b1);
        drive1("rst_b",   1'b1, 1'b1, 2'b11, 1'b1);
        drive1("rst_rel", 1'b0, 1'b1, 2'b11, 1'b1);

        // Full sweep: each lane with data 0 and data 1.
        for (int k = 0; k < 8; k++)
            drive1($sformatf("sweep%0d", k), 1'b0, 1'b1, 2'(k / 2), 1'(k % 2));

        // Back-to-back switching with data held high.
        drive1("b2b_00", 1'b0, 1'b1, 2'b00, 1'b1);
        drive1("b2b_11", 1'b0, 1'b1, 2'b11, 1'b1);
        drive1("b2b_01", 1'b0, 1'b1, 2'b01, 1'b1);

        // Enable gating and resume.
        drive1("en_off", 1'b0, 1'b0, 2'b10, 1'b1);
        drive1("en_on",  1'b0, 1'b1, 2'b10, 1'b1);

        // Mid-stream reset drops the routed value; nothing reappears afterwards.
        drive1("mid_run", 1'b0, 1'b1, 2'b01, 1'b1);
        drive1("mid_rst", 1'b1, 1'b1, 2'b10, 1'b1);
        drive1("mid_off", 1'b0, 1'b0, 2'b10, 1'b1);
        drive1("mid_new", 1'b0, 1'b1, 2'b00, 1'b1);

        // Wide data lanes.
        drive8("w_rst", 1'b1, 1'b1, 2'b11, 8'hFF);
        drive8("w_a5",  1'b0, 1'b1, 2'b10, 8'hA5);
        drive8("w_3c",  1'b0, 1'b1, 2'b01, 8'h3C);
        drive8("w_zero_sel3", 1'b0, 1'b1, 2'b11, 8'h00);
        for (int k = 0; k < 12; k++) begin
            rsel = 2'($urandom_range(0, 3));
            rdat = 8'($urandom_range(0, 255));
            drive8($sformatf("w_rnd%0d", k), 1'b0, (k % 5) != 4, rsel, rdat);
        end

        @(posedge clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);

        // Combinational build: settles without a clock edge; rst is ignored.
        busc.en = 1'b1; busc.s1 = 1'b0; busc.s0 = 1'b1; busc.i = 1'b1;
        #1;
        check("comb_y",  {28'b0, busc.y}, 32'h2);
        check("comb_la", {28'b0, busc.lane_active}, 32'h2);
        rst_c = 1'b1;
        @(posedge clk);
        #1;
        check("comb_rst_y", {28'b0, busc.y}, 32'h2);
        rst_c = 1'b0;
        busc.s1 = 1'b1; busc.s0 = 1'b1; busc.i = 1'b0;
        #1;
        check("comb_zero_y",  {28'b0, busc.y}, 32'h0);
        check("comb_zero_la", {28'b0, busc.lane_active}, 32'h8);
        busc.en = 1'b0; busc.i = 1'b1;
        #1;
        check("comb_en0_y",  {28'b0, busc.y}, 32'h0);
        check("comb_en0_la", {28'b0, busc.lane_active}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
